matrix_scan_controller: RTL and testbench

Sequencer for the RGB LED matrix row-scan datapath. It drives the row address into the row selector and the blank/latch strobes to the column drivers. It also hands off column-data shifting to the shift-register filler through a start/filled handshake. It sits between the top-level enable and the row/column output path, and owns all display timing, including the 300 ns blanking interval.

---
 rtl/matrix_scan_controller.sv | 141 ++++++++++++++
 tb/tb_matrix_scan_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// Row-scan sequencer for an RGB LED matrix: blank/latch/on timing plus shifter handshake.
// Optional binary-code modulation (8 bitplanes per row) is enabled by defining MATRIX_BCM_EN.
module matrix_scan_controller #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned BLANK_CYCLES = 30,
  parameter int unsigned LATCH_CYCLES = 2,
  parameter int unsigned ON_CYCLES    = 200,
  localparam int unsigned RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          is_filled,
  output logic          shift_start,
  output logic [RW-1:0] selected_row,
  output logic [2:0]    bit_plane,
  output logic          blank,
  output logic          latch,
  output logic          frame_done
);

  localparam int unsigned MaxCount = ON_CYCLES * 128 + BLANK_CYCLES + LATCH_CYCLES;
  localparam int unsigned CW       = $clog2(MaxCount + 1);

  typedef enum logic [2:0] {StIdle, StPreload, StBlank, StLatch, StOn} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   on_target;
  logic [RW-1:0]   pend_row;
  logic [RW-1:0]   next_row;
  logic [RW-1:0]   row_inc;
  logic [2:0]      pend_plane;
  logic [2:0]      next_plane;
  logic            fill;
  logic            fill_ok;
  logic            on_done;
  logic            last_plane;

  // A fill seen in the same cycle as shift_start belongs to the previous request.
  assign fill_ok = fill && !shift_start;
  assign on_done = (cnt >= on_target - 1'b1);

  always_comb begin
    row_inc = (selected_row == RW'(ROWS - 1)) ? '0 : selected_row + 1'b1;
`ifdef MATRIX_BCM_EN
    if (bit_plane == 3'd7) begin
      next_plane = 3'd0;
      next_row   = row_inc;
    end else begin
      next_plane = bit_plane + 1'b1;
      next_row   = selected_row;
    end
    on_target  = CW'(ON_CYCLES) << bit_plane;
    last_plane = (bit_plane == 3'd7);
`else
    next_plane = 3'd0;
    next_row   = row_inc;
    on_target  = CW'(ON_CYCLES);
    last_plane = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      pend_row     <= '0;
      pend_plane   <= '0;
      fill         <= 1'b0;
      selected_row <= '0;
      bit_plane    <= '0;
      blank        <= 1'b1;
      latch        <= 1'b0;
      shift_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      shift_start <= 1'b0;
      frame_done  <= 1'b0;
      cnt         <= cnt + 1'b1;
      if (shift_start) begin
        fill <= 1'b0;
      end else if (is_filled) begin
        fill <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          blank <= 1'b1;
          latch <= 1'b0;
          cnt   <= '0;
          if (enable) begin
            shift_start <= 1'b1;
            pend_row    <= '0;
            pend_plane  <= '0;
            state       <= StPreload;
          end
        end
        StPreload: begin
          cnt <= '0;
          if (fill_ok) begin
            state <= StBlank;
          end
        end
        StBlank: begin
          if (cnt == CW'(BLANK_CYCLES - 1)) begin
            selected_row <= pend_row;
            bit_plane    <= pend_plane;
            latch        <= 1'b1;
            cnt          <= '0;
            state        <= StLatch;
          end
        end
        StLatch: begin
          if (cnt == CW'(LATCH_CYCLES - 1)) begin
            latch       <= 1'b0;
            blank       <= 1'b0;
            shift_start <= 1'b1;
            pend_row    <= next_row;
            pend_plane  <= next_plane;
            cnt         <= '0;
            state       <= StOn;
          end
        end
        StOn: begin
          // Hold the counter once expired; on-time stretches until the next row is filled.
          if (on_done) begin
            cnt <= cnt;
          end
          if (on_done && fill_ok) begin
            blank      <= 1'b1;
            cnt        <= '0;
            frame_done <= (selected_row == RW'(ROWS - 1)) && last_plane;
            state      <= enable ? StBlank : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller at default parameters, with a shifter model
// and a scoreboard of expected ON windows (row, plane, lit duration).
module tb_matrix_scan_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       is_filled = 1'b0;
  logic       shift_start;
  logic [2:0] selected_row;
  logic [2:0] bit_plane;
  logic       blank;
  logic       latch;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fill_delay = 3;
  int cd = 0;
  int fill_cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int fd_row = 0;
  logic       prev_latch = 1'b0;
  logic       prev_blank = 1'b1;
  logic [2:0] prev_row = 3'd0;

  typedef struct {
    int row;
    int plane;
    int len;
  } exp_t;
  exp_t sb[$];

  matrix_scan_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .is_filled    (is_filled),
    .shift_start  (shift_start),
    .selected_row (selected_row),
    .bit_plane    (bit_plane),
    .blank        (blank),
    .latch        (latch),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Column shifter model: is_filled rises fill_delay cycles after each shift_start.
  always @(negedge clk) begin
    if (reset) begin
      cd = 0;
      is_filled = 1'b0;
    end else if (shift_start) begin
      cd = fill_delay;
      is_filled = 1'b0;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        is_filled = 1'b1;
        fill_cyc = cyc;
      end
    end
  end

  // Continuous invariants and frame_done recording.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (latch === 1'b1 && blank === 1'b0) begin
        errors++;
        $display("FAIL latch_while_lit: latch=%b blank=%b at cycle %0d, latch must imply blank",
                 latch, blank, cyc);
      end
      if ((latch === 1'b1 || blank === 1'b0) && (prev_latch === 1'b1 || prev_blank === 1'b0)) begin
        checks++;
        if (selected_row !== prev_row) begin
          errors++;
          $display("FAIL row_stable: row went %0d -> %0d at cycle %0d while lit/latched",
                   prev_row, selected_row, cyc);
        end
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_cyc = cyc;
        fd_row = selected_row;
      end
    end
    prev_latch = latch;
    prev_blank = blank;
    prev_row   = selected_row;
  end

  // Waits for the next lit window and measures it; an expired bound counts as a failure.
  task automatic wait_window(input int drop_at, output int row, output int plane,
                             output int len, output int start_c, output int end_c);
    int n;
    n = 0;
    len = 0;
    while (blank !== 1'b0 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60000) begin
      errors++;
      $display("FAIL window_timeout: no blank=0 within %0d cycles", n);
    end
    start_c = cyc;
    row = selected_row;
    plane = bit_plane;
    while (blank === 1'b0 && len < 60000) begin
      len++;
      if (len == drop_at) enable = 1'b0;
      @(negedge clk);
    end
    end_c = cyc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rst_blank: got %b want 1", blank); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", latch); end
    checks++;
    if (shift_start !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b want 0", shift_start); end
    checks++;
    if (selected_row !== 3'd0) begin errors++; $display("FAIL rst_row: got %0d want 0", selected_row); end
    checks++;
    if (bit_plane !== 3'd0) begin errors++; $display("FAIL rst_plane: got %0d want 0", bit_plane); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (blank !== 1'b1 || shift_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: blank=%b shift=%b want 1/0 with enable low", blank, shift_start);
    end
  endtask

  task automatic test_preload;
    int n;
    int lw;
    bit bad;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (shift_start !== 1'b1) begin
      errors++;
      $display("FAIL first_shift: got %b want 1 one cycle after enable", shift_start);
    end
    bad = 1'b0;
    n = 0;
    while (latch !== 1'b1 && n < 1000) begin
      if (blank !== 1'b1) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad || n >= 1000) begin
      errors++;
      $display("FAIL preload_blank: blank dropped=%0d cycles=%0d want blank held until latch", bad, n);
    end
    lw = 0;
    while (latch === 1'b1 && lw < 100) begin
      lw++;
      @(negedge clk);
    end
    checks++;
    if (lw != 2) begin errors++; $display("FAIL latch_width: got %0d want 2", lw); end
  endtask

  task automatic test_free_run;
    int row, plane, len, sc, ec, prev_sc, end7;
    exp_t e;
    for (int r = 0; r < 9; r++) sb.push_back('{r % 8, 0, 200});
    fd_count = 0;
    prev_sc = 0;
    end7 = -1;
    for (int i = 0; i < 9; i++) begin
      wait_window(-1, row, plane, len, sc, ec);
      e = sb.pop_front();
      checks++;
      if (row != e.row) begin errors++; $display("FAIL run_row[%0d]: got %0d want %0d", i, row, e.row); end
      checks++;
      if (len != e.len) begin errors++; $display("FAIL run_len[%0d]: got %0d want %0d", i, len, e.len); end
      if (i > 0) begin
        checks++;
        if (sc - prev_sc != 232) begin
          errors++;
          $display("FAIL row_period[%0d]: got %0d want 232", i, sc - prev_sc);
        end
      end
      if (e.row == 7) end7 = ec;
      prev_sc = sc;
    end
    checks++;
    if (fd_count != 1) begin errors++; $display("FAIL fd_count: got %0d want 1", fd_count); end
    checks++;
    if (fd_row != 7 || fd_cyc != end7) begin
      errors++;
      $display("FAIL fd_place: row=%0d cyc=%0d want row 7 cyc %0d", fd_row, fd_cyc, end7);
    end
  endtask

  task automatic test_stall;
    int row, plane, len, sc, ec;
    exp_t e;
    fill_delay = 248;
    sb.push_back('{1, 0, 250});
    wait_window(-1, row, plane, len, sc, ec);
    fill_delay = 3;
    e = sb.pop_front();
    checks++;
    if (row != e.row || len != e.len) begin
      errors++;
      $display("FAIL stall_len: row=%0d len=%0d want row %0d len %0d", row, len, e.row, e.len);
    end
    checks++;
    if (ec != fill_cyc + 2) begin
      errors++;
      $display("FAIL stall_exit: blank rose at %0d want %0d", ec, fill_cyc + 2);
    end
  endtask

  task automatic test_drop_enable;
    int row, plane, len, sc, ec;
    bit bad;
    exp_t e;
    sb.push_back('{2, 0, 200});
    sb.push_back('{3, 0, 200});
    for (int i = 0; i < 2; i++) begin
      wait_window(i == 1 ? 100 : -1, row, plane, len, sc, ec);
      e = sb.pop_front();
      checks++;
      if (row != e.row || len != e.len) begin
        errors++;
        $display("FAIL drop_win[%0d]: row=%0d len=%0d want row %0d len %0d", i, row, len, e.row, e.len);
      end
    end
    bad = 1'b0;
    repeat (300) begin
      if (latch !== 1'b0 || blank !== 1'b1 || shift_start !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_quiet: activity=%0d want 0 while disabled", bad); end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (shift_start !== 1'b1) begin errors++; $display("FAIL reenable_shift: got %b want 1", shift_start); end
    sb.push_back('{0, 0, 200});
    wait_window(-1, row, plane, len, sc, ec);
    e = sb.pop_front();
    checks++;
    if (row != e.row || len != e.len) begin
      errors++;
      $display("FAIL restart_win: row=%0d len=%0d want row %0d len %0d", row, len, e.row, e.len);
    end
  endtask

  task automatic test_reset_latch;
    int row, plane, len, sc, ec, n;
    exp_t e;
    for (int r = 1; r < 5; r++) sb.push_back('{r, 0, 200});
    for (int i = 0; i < 4; i++) begin
      wait_window(-1, row, plane, len, sc, ec);
      e = sb.pop_front();
      checks++;
      if (row != e.row || len != e.len) begin
        errors++;
        $display("FAIL pre_rst_win[%0d]: row=%0d len=%0d want %0d/%0d", i, row, len, e.row, e.len);
      end
    end
    n = 0;
    while (latch !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (selected_row !== 3'd5) begin errors++; $display("FAIL latch_row: got %0d want 5", selected_row); end
    reset = 1'b1;
    #1;
    checks++;
    if (blank !== 1'b1 || latch !== 1'b0 || selected_row !== 3'd0 || shift_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: blank=%b latch=%b row=%0d shift=%b want 1/0/0/0",
               blank, latch, selected_row, shift_start);
    end
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef MATRIX_BCM_EN
  task automatic test_bcm;
    int row, plane, len, sc, ec;
    exp_t e;
    for (int p = 0; p < 8; p++) sb.push_back('{0, p, 200 << p});
    sb.push_back('{1, 0, 200});
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_window(-1, row, plane, len, sc, ec);
      e = sb.pop_front();
      checks++;
      if (row != e.row || plane != e.plane || len != e.len) begin
        errors++;
        $display("FAIL bcm_win[%0d]: row=%0d plane=%0d len=%0d want %0d/%0d/%0d",
                 i, row, plane, len, e.row, e.plane, e.len);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef MATRIX_BCM_EN
    test_bcm;
`else
    test_preload;
    test_free_run;
    test_stall;
    test_drop_enable;
    test_reset_latch;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
